// File: rtl/ysyx_25030081_ifu_pkg.sv
// Shared types and constants for the ysyx_25030081 instruction fetch unit.
package ysyx_25030081_ifu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } ifu_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [31:0] INST_NOP         = 32'h0000_0013;

  function automatic logic is_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage

// File: rtl/ysyx_25030081_pc_reg.sv
// Architectural PC register: async active-low reset to RESET_PC, loads d when we is high.
module ysyx_25030081_pc_reg
  import ysyx_25030081_ifu_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = RESET_PC_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  logic [DATA_WIDTH-1:0] pc_r;

  // PC storage, written only on the decode handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r <= RESET_PC;
    end else if (we) begin
      pc_r <= d;
    end
  end

  assign q = pc_r;

endmodule

// File: rtl/ysyx_25030081_ifu.sv
// Instruction fetch unit: PC ownership, imem request/response FSM and decode buffer.
// Optional macro YSYX_25030081_IFU_ALIGN_CHECK_EN turns misaligned fetches into local faults.
module ysyx_25030081_ifu
  import ysyx_25030081_ifu_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = RESET_PC_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] next_pc,
  output logic [DATA_WIDTH-1:0] pc,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [DATA_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  input  logic                  imem_rsp_err,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [DATA_WIDTH-1:0] inst,
  output logic [DATA_WIDTH-1:0] inst_pc,
  output logic                  inst_err
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_REQ  = REQ;
  localparam logic [1:0] S_WAIT = WAIT;
  localparam logic [1:0] S_HOLD = HOLD;

  logic [1:0]            state_r;
  logic [1:0]            state_nxt_s;
  logic                  req_valid_r;
  logic                  inst_valid_r;
  logic                  inst_err_r;
  logic [DATA_WIDTH-1:0] inst_r;
  logic [DATA_WIDTH-1:0] pc_s;
  logic [DATA_WIDTH-1:0] pc_nxt_s;
  logic                  pc_we_s;
  logic                  misalign_s;
  logic                  misalign_nxt_s;

  assign pc_we_s  = inst_valid_r & inst_ready;
  assign pc_nxt_s = pc_we_s ? next_pc : pc_s;

`ifdef YSYX_25030081_IFU_ALIGN_CHECK_EN
  assign misalign_s     = ~is_aligned(pc_s[1:0]);
  assign misalign_nxt_s = ~is_aligned(pc_nxt_s[1:0]);
`else
  assign misalign_s     = 1'b0;
  assign misalign_nxt_s = 1'b0;
`endif

  ysyx_25030081_pc_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .RESET_PC   (RESET_PC)
  ) u_pc_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (pc_we_s),
    .d     (next_pc),
    .q     (pc_s)
  );

  // Fetch FSM next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: state_nxt_s = S_REQ;
      S_REQ: begin
        if (misalign_s) begin
          state_nxt_s = S_HOLD;
        end else if (imem_req_ready) begin
          state_nxt_s = S_WAIT;
        end else begin
          state_nxt_s = S_REQ;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          state_nxt_s = S_HOLD;
        end else begin
          state_nxt_s = S_WAIT;
        end
      end
      S_HOLD: begin
        if (inst_ready) begin
          state_nxt_s = S_REQ;
        end else begin
          state_nxt_s = S_HOLD;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State plus handshake valids, registered from the next state so outputs are glitch-free
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= S_IDLE;
      req_valid_r  <= 1'b0;
      inst_valid_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      req_valid_r  <= (state_nxt_s == S_REQ) & ~misalign_nxt_s;
      inst_valid_r <= (state_nxt_s == S_HOLD);
    end
  end

  // Instruction buffer; a misaligned fetch is delivered as a zero word with the fault flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_r     <= {DATA_WIDTH{1'b0}};
      inst_err_r <= 1'b0;
    end else if ((state_r == S_WAIT) && imem_rsp_valid) begin
      inst_r     <= imem_rsp_data;
      inst_err_r <= imem_rsp_err;
    end else if ((state_r == S_REQ) && misalign_s) begin
      inst_r     <= {DATA_WIDTH{1'b0}};
      inst_err_r <= 1'b1;
    end
  end

  assign pc             = pc_s;
  assign imem_req_addr  = pc_s;
  assign imem_req_valid = req_valid_r;
  assign inst_valid     = inst_valid_r;
  assign inst           = inst_r;
  assign inst_pc        = pc_s;
  assign inst_err       = inst_err_r;

endmodule

// File: tb/tb_ysyx_25030081_ifu.sv
// Scoreboard bench for ysyx_25030081_ifu: memory/decode model drives stimulus, a monitor checks deliveries.
module tb_ysyx_25030081_ifu;
  import ysyx_25030081_ifu_pkg::*;

  localparam logic [31:0] RPC = RESET_PC_DEFAULT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] next_pc;
  logic [31:0] pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_err;

  always #5 clk = ~clk;

  ysyx_25030081_ifu dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .next_pc        (next_pc),
    .pc             (pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_err       (inst_err)
  );

  typedef struct packed {
    logic [31:0] epc;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] model_pc;
  int          cyc, first_req, first_inst;
  // memory model
  logic        rsp_pending;
  int          rsp_delay;
  logic [31:0] rsp_data_m;
  logic        rsp_err_m;
  logic        acc_last;
  logic        prev_req_stall;
  logic [31:0] prev_addr;
  // stimulus knobs: mode 0 random, 1 always high, 2 always low
  int          ready_mode, dready_mode, max_delay, force_mode;
  logic [31:0] force_data;
  logic        force_err, stray_en, rand_target, fixed_pending;
  logic [31:0] fixed_pc;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus, decided at the falling edge for the following rising edge
  task automatic step();
    exp_t        e;
    logic [31:0] np;
    @(negedge clk);
    cyc++;
    if (imem_req_valid && first_req < 0) first_req = cyc;
    if (inst_valid && first_inst < 0) first_inst = cyc;
    check32("pc", pc, model_pc);
    if (prev_req_stall) begin
      check1("req_hold_valid", imem_req_valid, 1'b1);
      check32("req_hold_addr", imem_req_addr, prev_addr);
    end
    if (ready_mode == 0) imem_req_ready = ($urandom_range(0, 1) == 1);
    else imem_req_ready = (ready_mode == 1);
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    imem_rsp_err   = ($urandom_range(0, 1) == 1);
    if (rsp_pending) begin
      if (rsp_delay == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = rsp_data_m;
        imem_rsp_err   = rsp_err_m;
        rsp_pending    = 1'b0;
      end else begin
        rsp_delay--;
      end
    end else if (stray_en && (imem_req_valid || inst_valid) &&
                 !(imem_req_valid && imem_req_ready) && $urandom_range(0, 3) == 0) begin
      imem_rsp_valid = 1'b1;
    end
    acc_last = imem_req_valid && imem_req_ready;
    if (acc_last) begin
      check32("req_addr", imem_req_addr, model_pc);
      e.epc = model_pc;
      if (force_mode != 0) begin
        e.data = force_data;
        e.err  = force_err;
        if (force_mode == 2) force_mode = 0;
      end else begin
        e.data = $urandom;
        e.err  = ($urandom_range(0, 7) == 0);
      end
      exp_q.push_back(e);
      rsp_pending = 1'b1;
      rsp_delay   = $urandom_range(0, max_delay);
      rsp_data_m  = e.data;
      rsp_err_m   = e.err;
    end
    prev_req_stall = imem_req_valid && !imem_req_ready;
    prev_addr      = imem_req_addr;
    if (dready_mode == 0) inst_ready = ($urandom_range(0, 1) == 1);
    else inst_ready = (dready_mode == 1);
    if (fixed_pending) begin
      np = fixed_pc;
    end else if (rand_target && $urandom_range(0, 3) == 0) begin
      np = $urandom;
      np[1:0] = 2'b00;
    end else begin
      np = (model_pc & 32'hFFFF_FFFC) + 32'd4;
    end
    next_pc = np;
    if (inst_valid && inst_ready) begin
      model_pc      = np;
      fixed_pending = 1'b0;
`ifdef YSYX_25030081_IFU_ALIGN_CHECK_EN
      if (np[1:0] != 2'b00) begin
        e.epc  = np;
        e.data = 32'h0;
        e.err  = 1'b1;
        exp_q.push_back(e);
      end
`endif
    end
  endtask

  // Monitor: pops the scoreboard on every decode handshake and checks HOLD stability
  logic        hold_prev;
  logic [31:0] hold_inst, hold_pc;
  logic        hold_err;
  initial begin
    exp_t e;
    hold_prev = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        hold_prev = 1'b0;
      end else begin
        if (hold_prev) begin
          check1("hold_valid", inst_valid, 1'b1);
          check32("hold_inst", inst, hold_inst);
          check32("hold_inst_pc", inst_pc, hold_pc);
          check1("hold_err", inst_err, hold_err);
        end
        if (inst_valid) check32("inst_pc_eq_pc", inst_pc, pc);
        if (inst_valid && inst_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_inst: got inst %h at pc %h, expected none", inst, inst_pc);
          end else begin
            e = exp_q.pop_front();
            check32("inst", inst, e.data);
            check32("inst_pc", inst_pc, e.epc);
            check1("inst_err", inst_err, e.err);
          end
        end
        hold_prev = inst_valid && !inst_ready;
        hold_inst = inst;
        hold_pc   = inst_pc;
        hold_err  = inst_err;
      end
    end
  end

  task automatic reset_model();
    exp_q.delete();
    model_pc       = RPC;
    rsp_pending    = 1'b0;
    prev_req_stall = 1'b0;
    fixed_pending  = 1'b0;
  endtask

  task automatic set_clean();
    ready_mode  = 1;
    dready_mode = 1;
    max_delay   = 0;
    force_mode  = 0;
    stray_en    = 1'b0;
    rand_target = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check32({tag, "_pc"}, pc, RPC);
    check1({tag, "_req_valid"}, imem_req_valid, 1'b0);
    check1({tag, "_inst_valid"}, inst_valid, 1'b0);
    check32({tag, "_inst"}, inst, 32'h0);
    check1({tag, "_inst_err"}, inst_err, 1'b0);
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out, expected event within bound", name);
  endtask

  initial begin
    int k;
    next_pc = RPC; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'h0; imem_rsp_err = 1'b0; inst_ready = 1'b0;
    reset_model();
    set_clean();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");

    // Release at a falling edge; cycle 1 is the first full cycle after release.
    rst_n = 1'b1; cyc = 0; first_req = -1; first_inst = -1;
    force_mode = 1; force_data = INST_NOP; force_err = 1'b0;
    repeat (24) step();
    check32("first_req_cycle", first_req, 32'd1);
    check32("first_inst_cycle", first_inst, 32'd3);
    check32("seq_pc_after_8", model_pc, 32'h8000_0020);
    force_mode = 0;

    // Branch target taken at the next handshake
    fixed_pc = 32'h8000_0100; fixed_pending = 1'b1;
    k = 0;
    while (fixed_pending && k < 20) begin step(); k++; end
    if (fixed_pending) fail_timeout("branch_handshake");
    step();
    check32("branch_addr", imem_req_addr, 32'h8000_0100);

    // Memory back-pressure: five stalled cycles, accepted on the sixth
    ready_mode = 2;
    k = 0;
    do begin step(); k++; end while (!imem_req_valid && k < 20);
    if (!imem_req_valid) fail_timeout("req_stall_start");
    repeat (4) step();
    ready_mode = 1;
    step();
    check1("req_accept_after_stall", acc_last, 1'b1);

    // Decode back-pressure for four cycles in HOLD
    dready_mode = 2;
    k = 0;
    do begin step(); k++; end while (!inst_valid && k < 20);
    if (!inst_valid) fail_timeout("hold_start");
    repeat (4) step();
    check1("no_req_in_hold", imem_req_valid, 1'b0);
    dready_mode = 1;

    // Error response delivered like data
    force_mode = 2; force_data = 32'hDEAD_BEEF; force_err = 1'b1;
    k = 0;
    while (force_mode != 0 && k < 20) begin step(); k++; end
    if (force_mode != 0) fail_timeout("err_accept");
    repeat (6) step();

    // Misaligned target
    fixed_pc = 32'h8000_0002; fixed_pending = 1'b1;
    repeat (12) step();

    // Randomized traffic with stray responses
    ready_mode = 0; dready_mode = 0; max_delay = 3; stray_en = 1'b1; rand_target = 1'b1;
    repeat (400) step();

    // Reset while waiting on a response, then a late response after release
    k = 0;
    do begin step(); k++; end while (!acc_last && k < 50);
    if (!acc_last) fail_timeout("accept_before_reset");
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    reset_model();
    set_clean();
    @(negedge clk);
    rst_n = 1'b1;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1234_5678; imem_rsp_err = 1'b1;
    inst_ready = 1'b0; imem_req_ready = 1'b0; next_pc = RPC;
    cyc = 0; first_req = -1; first_inst = -1;
    repeat (12) step();
    check32("restart_first_req", first_req, 32'd1);
    check32("restart_first_inst", first_inst, 32'd3);

    ready_mode = 0; dready_mode = 0; max_delay = 3; stray_en = 1'b1; rand_target = 1'b1;
    repeat (200) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_25030081_ifu.md
Name: ysyx_25030081_ifu

Overview:
- Instruction fetch unit; owns the architectural PC register.
- Drives `pc` into the downstream next-PC logic, which returns `next_pc`.
- Fetches the instruction at `pc` from instruction memory over a valid/ready request channel and a valid-only response channel.
- Presents the fetched instruction to decode with a valid/ready handshake.
- Updates `pc` from `next_pc` only when decode accepts an instruction.

Parameters:
- DATA_WIDTH, 32, width of PC, addresses and instruction word.
- RESET_PC, 32'h8000_0000, PC value loaded on reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- next_pc  input  DATA_WIDTH  PC for the following instruction, combinational from the next-PC stage.
- pc  output  DATA_WIDTH  current architectural PC.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_req_addr  output  DATA_WIDTH  fetch address; always equals pc.
- imem_rsp_valid  input  1  response data valid; one-cycle pulse.
- imem_rsp_data  input  DATA_WIDTH  fetched instruction.
- imem_rsp_err  input  1  access fault, qualified by imem_rsp_valid.
- inst_valid  output  1  instruction available to decode.
- inst_ready  input  1  decode accepts instruction.
- inst  output  DATA_WIDTH  registered instruction word.
- inst_pc  output  DATA_WIDTH  PC of inst; equals pc while inst_valid.
- inst_err  output  1  fetch fault flag for inst.

Behaviour:
- Reset (async assert, sync release):
  - pc=RESET_PC, state=IDLE.
  - imem_req_valid=0, inst_valid=0, inst=0, inst_err=0.
- FSM states: IDLE, REQ, WAIT, HOLD.
  - IDLE: unconditional move to REQ on the next cycle. The first request issues on the 2nd cycle after reset release.
  - REQ: imem_req_valid=1, addr=pc. Stay in REQ until imem_req_ready=1 on a rising edge, then go to WAIT. The address must stay stable while valid and not accepted.
  - WAIT: imem_req_valid=0. On imem_rsp_valid, capture data and err into inst/inst_err, then go to HOLD.
  - HOLD: inst_valid=1; inst, inst_pc and inst_err stay stable. On inst_valid&inst_ready: pc<=next_pc, inst_valid<=0, go to REQ.
- Timing rules:
  - The response arrives at least 1 cycle after the request is accepted. A response in the same cycle as acceptance is illegal.
  - imem_rsp_valid outside WAIT is ignored and does not change state.
- Minimum latency per instruction: REQ, WAIT, HOLD = 3 cycles with zero-wait memory and always-ready decode.
- pc changes only on the decode handshake. next_pc is sampled only in that cycle; no width changes, the full DATA_WIDTH is loaded.
- inst_ready while inst_valid=0 has no effect.
- Wrap-around: next_pc=32'hFFFF_FFFC followed by +4 reaches 0. No special handling.
- An error response is delivered like data: inst=imem_rsp_data, inst_err=1. The FSM proceeds normally; the fault is handled downstream.
- Reset asserted mid-transaction (REQ/WAIT/HOLD): return to IDLE immediately. Any late response is dropped because the FSM is not in WAIT when it arrives.

Optional Feature:
- Macro: YSYX_25030081_IFU_ALIGN_CHECK_EN.
- Defined: in REQ with pc[1:0]!=0, no memory request is issued (imem_req_valid=0). The FSM goes directly to HOLD with inst=0 and inst_err=1 on the next cycle.
- Undefined: no check; pc[1:0] is passed through on imem_req_addr unchanged.

Decomposition:
- Shared package ysyx_25030081_ifu_pkg:
  - ifu_state_t enum {IDLE, REQ, WAIT, HOLD}.
  - RESET_PC_DEFAULT constant.
  - INST_NOP = 32'h0000_0013 constant, used by test benches.
- One natural sub-module: ysyx_25030081_pc_reg. It is a DATA_WIDTH register with async active-low reset to RESET_PC and a write enable (the decode handshake).
- The FSM and instruction buffer stay in the top module.

Test Plan:
- Reset release with req_ready=1, rsp_valid 1 cycle after acceptance, data 32'h0000_0013, inst_ready=1 -> imem_req_addr=32'h8000_0000 on cycle 2; inst_valid on cycle 4 with inst=32'h13, inst_pc=32'h8000_0000.
- next_pc=32'h8000_0004 at handshake -> next request addr=32'h8000_0004 and pc=32'h8000_0004. Repeat for 8 instructions; also check a branch with next_pc=32'h8000_0100.
- Hold req_ready=0 for 5 cycles -> req_valid stays 1, addr stable, no state change; accepted on cycle 6.
- inst_ready=0 for 4 cycles in HOLD -> inst, inst_pc and inst_valid stable, pc unchanged, no new request.
- rsp_err=1 with data 32'hDEAD_BEEF -> inst=32'hDEAD_BEEF, inst_err=1. A stray rsp_valid in REQ is ignored.
- rst_n pulsed low in WAIT, then a late response arrives -> outputs return to reset values, the response is dropped, and fetch restarts at 32'h8000_0000. With ALIGN_CHECK_EN and next_pc=32'h8000_0002 -> no request, inst_err=1.
